// File: rtl/mem_preload_ctrl.sv
// Preload sequencer: streams source words into memory at base_addr + i while
// holding the CPU off the bus, then optionally reads the region back and compares checksums.
module mem_preload_ctrl #(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  verify_en,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  src_valid,
  input  logic [REG_WIDTH-1:0]  src_data,
  output logic                  src_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  verify_q, verify_d;
  logic [REG_WIDTH-1:0]  wsum_q, wsum_d;
  logic [REG_WIDTH-1:0]  rsum_q, rsum_d;
  logic                  error_q, error_d;
  logic                  rd_pend_q, rd_pend_d;

  logic [ADDR_WIDTH:0]   len_m1;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  last_word;

  // Address arithmetic drops the carry so a region past top-of-memory wraps to 0.
  assign len_m1    = len_q - CNT_ONE;
  assign cur_addr  = base_q + count_q[ADDR_WIDTH-1:0];
  assign last_word = (count_q == len_m1);

  // NOTE: every signal assigned in this block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    count_d   = count_q;
    verify_d  = verify_q;
    wsum_d    = wsum_q;
    rsum_d    = rsum_q;
    error_d   = error_q;
    rd_pend_d = 1'b0;
    src_ready = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    // Read data returns one cycle after mem_re; accumulate it wherever it lands.
    if (rd_pend_q) begin
      rsum_d = rsum_q + mem_rdata;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (length != '0) begin
            base_d   = base_addr;
            len_d    = length;
            verify_d = verify_en;
            count_d  = '0;
            wsum_d   = '0;
            rsum_d   = '0;
            state_d  = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_LOAD: begin
        src_ready = 1'b1;
        mem_addr  = cur_addr;
        mem_wdata = src_data;
        mem_we    = src_valid;
        if (src_valid) begin
          wsum_d  = wsum_q + src_data;
          count_d = count_q + CNT_ONE;
          if (last_word) begin
            count_d = '0;
            state_d = verify_q ? S_VERIFY : S_DONE;
          end
        end
      end

      S_VERIFY: begin
        mem_re    = 1'b1;
        mem_addr  = cur_addr;
        rd_pend_d = 1'b1;
        count_d   = count_q + CNT_ONE;
        if (last_word) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // rsum_d already holds the final read word, so the flag is valid alongside done.
        error_d = (wsum_q != rsum_d);
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      error_d   = error_q;
      rd_pend_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      count_q   <= '0;
      verify_q  <= 1'b0;
      wsum_q    <= '0;
      rsum_q    <= '0;
      error_q   <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      count_q   <= count_d;
      verify_q  <= verify_d;
      wsum_q    <= wsum_d;
      rsum_q    <= rsum_d;
      error_q   <= error_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign cpu_hold = busy;
  assign done     = (state_q == S_DONE);
  assign error    = error_q;

endmodule

// File: tb/tb_mem_preload_ctrl.sv
// Scoreboard bench for mem_preload_ctrl: stimulus pushes expected writes, reads and
// done pulses (with spec cycle numbers) into queues; a negedge monitor pops and compares.
module tb_mem_preload_ctrl;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [15:0] addr;
    int          cyc;
  } rd_t;

  typedef struct {
    logic err;
    int   cyc;
  } dn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        verify_en = 1'b0;
  logic [15:0] base_addr = '0;
  logic [16:0] length = '0;
  logic        src_valid = 1'b0;
  logic [7:0]  src_data = '0;
  logic        src_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata = '0;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int last_busy_len = 0;
  logic corrupt = 1'b0;

  logic [7:0] mem [0:65535];
  logic [7:0] dbuf [0:7];
  bit         vpat [0:7];

  wr_t wq[$];
  rd_t rq[$];
  dn_t dq[$];

  mem_preload_ctrl #(.REG_WIDTH(8), .ADDR_WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .verify_en (verify_en),
    .base_addr (base_addr),
    .length    (length),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: synchronous write, read data one cycle after mem_re; optional fault at 0x0000.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= (corrupt && mem_addr == 16'h0000) ? mem[mem_addr] + 8'h01 : mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: spec cycle number of the current period is cyc+1 (period after edge n is cycle n+1).
  always @(negedge clk) begin
    automatic int now = cyc + 1;
    check("hold_eq_busy", {31'b0, cpu_hold}, {31'b0, busy});
    check("we_re_exclusive", {31'b0, mem_we & mem_re}, 32'd0);
    if (mem_we) begin
      if (wq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: got addr=%h data=%h expected no write", mem_addr, mem_wdata);
      end else begin
        automatic wr_t e = wq.pop_front();
        check("wr_addr", {16'b0, mem_addr}, {16'b0, e.addr});
        check("wr_data", {24'b0, mem_wdata}, {24'b0, e.data});
        check("wr_cycle", now, e.cyc);
      end
    end
    if (mem_re) begin
      if (rq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_read: got addr=%h expected no read", mem_addr);
      end else begin
        automatic rd_t e = rq.pop_front();
        check("rd_addr", {16'b0, mem_addr}, {16'b0, e.addr});
        check("rd_cycle", now, e.cyc);
      end
    end
    if (done) begin
      if (dq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done=1 expected 0 at cycle %0d", now);
      end else begin
        automatic dn_t e = dq.pop_front();
        check("done_cycle", now, e.cyc);
        check("done_error", {31'b0, error}, {31'b0, e.err});
      end
    end
    if (busy) busy_cnt++;
    else if (busy_cnt != 0) begin
      last_busy_len = busy_cnt;
      busy_cnt = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [15:0] base, input logic [16:0] len, input logic ver, output int t);
    step();
    start     = 1'b1;
    base_addr = base;
    length    = len;
    verify_en = ver;
    t         = cyc + 1;
  endtask

  // Drives ncyc LOAD cycles with vpat/dbuf and pushes the expected writes.
  task automatic feed(input int t, input int ncyc, input logic [15:0] base);
    int idx = 0;
    for (int j = 0; j < ncyc; j++) begin
      step();
      start     = 1'b0;
      src_valid = vpat[j];
      src_data  = dbuf[idx];
      if (vpat[j]) begin
        wq.push_back('{addr: base + 16'(idx), data: dbuf[idx], cyc: t + 1 + j});
        idx++;
      end
    end
    step();
    src_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (!busy && dq.size() == 0) return;
    end
    total++; bad++;
    $display("FAIL wait_idle: got busy=%0b pending_done=%0d expected idle within %0d cycles", busy, dq.size(), budget);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_src_ready"}, {31'b0, src_ready}, 32'd0);
    check({tag, "_mem_we"},    {31'b0, mem_we},    32'd0);
    check({tag, "_mem_re"},    {31'b0, mem_re},    32'd0);
    check({tag, "_cpu_hold"},  {31'b0, cpu_hold},  32'd0);
    check({tag, "_busy"},      {31'b0, busy},      32'd0);
    check({tag, "_done"},      {31'b0, done},      32'd0);
    check({tag, "_error"},     {31'b0, error},     32'd0);
    check({tag, "_mem_addr"},  {16'b0, mem_addr},  32'd0);
    check({tag, "_mem_wdata"}, {24'b0, mem_wdata}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;

    // Reset state
    repeat (3) step();
    check_outputs_zero("reset");
    reset = 1'b0;
    step();

    // 1) base 0x0010, L=4, no verify: writes t+1..t+4, done t+5, busy 5 cycles
    dbuf[0] = 8'h11; dbuf[1] = 8'h22; dbuf[2] = 8'h33; dbuf[3] = 8'h44;
    for (int j = 0; j < 8; j++) vpat[j] = 1'b1;
    start_op(16'h0010, 17'd4, 1'b0, t);
    dq.push_back('{err: 1'b0, cyc: t + 5});
    feed(t, 4, 16'h0010);
    wait_idle(20);
    step();
    check("busy_len_case1", last_busy_len, 5);
    check("err_case1", {31'b0, error}, 32'd0);

    // 2) base 0xFFFE, L=4, verify, wraps to 0x0000: reads t+5..t+8, done t+10, no error
    start_op(16'hFFFE, 17'd4, 1'b1, t);
    for (int i = 0; i < 4; i++) rq.push_back('{addr: 16'hFFFE + 16'(i), cyc: t + 5 + i});
    dq.push_back('{err: 1'b0, cyc: t + 10});
    feed(t, 4, 16'hFFFE);
    wait_idle(30);
    check("mem_wrap_0000", {24'b0, mem[16'h0000]}, 32'h33);

    // 3) same with 0x0000 read corrupted 0x33->0x34: error with done, held afterwards
    corrupt = 1'b1;
    start_op(16'hFFFE, 17'd4, 1'b1, t);
    for (int i = 0; i < 4; i++) rq.push_back('{addr: 16'hFFFE + 16'(i), cyc: t + 5 + i});
    dq.push_back('{err: 1'b1, cyc: t + 10});
    feed(t, 4, 16'hFFFE);
    wait_idle(30);
    repeat (3) step();
    check("err_held", {31'b0, error}, 32'd1);
    corrupt = 1'b0;

    // 4) L=3, src_valid 1,0,0,1,0,1: writes at t+1,t+4,t+6, done t+7; start clears error
    dbuf[0] = 8'hA1; dbuf[1] = 8'hB2; dbuf[2] = 8'hC3;
    vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1; vpat[4] = 0; vpat[5] = 1;
    start_op(16'h0200, 17'd3, 1'b0, t);
    dq.push_back('{err: 1'b0, cyc: t + 7});
    feed(t, 6, 16'h0200);
    check("err_cleared_by_start", {31'b0, error}, 32'd0);
    wait_idle(20);
    check("mem_0201", {24'b0, mem[16'h0201]}, 32'hB2);

    // 5) abort after 2 of 8 words; start while busy ignored
    start_op(16'h0300, 17'd8, 1'b0, t);
    step();
    start = 1'b0; src_valid = 1'b1; src_data = 8'h51;
    wq.push_back('{addr: 16'h0300, data: 8'h51, cyc: t + 1});
    step();
    src_data = 8'h52; start = 1'b1; base_addr = 16'h0400; length = 17'd1;
    wq.push_back('{addr: 16'h0301, data: 8'h52, cyc: t + 2});
    step();
    start = 1'b0; src_valid = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_cpu_hold", {31'b0, cpu_hold}, 32'd0);
    check("abort_src_ready", {31'b0, src_ready}, 32'd0);
    repeat (3) step();
    check("abort_mem_300", {24'b0, mem[16'h0300]}, 32'h51);
    check("abort_mem_301", {24'b0, mem[16'h0301]}, 32'h52);
    check("abort_mem_302", {24'b0, mem[16'h0302]}, 32'h00);
    check("abort_mem_400", {24'b0, mem[16'h0400]}, 32'h00);

    // 6) L=0: done at t+1, no memory access
    start_op(16'h0700, 17'd0, 1'b1, t);
    dq.push_back('{err: 1'b0, cyc: t + 1});
    step();
    start = 1'b0;
    wait_idle(10);

    // 7) reset mid-VERIFY: outputs drop immediately, idle after release
    dbuf[0] = 8'h01; dbuf[1] = 8'h02; dbuf[2] = 8'h03; dbuf[3] = 8'h04;
    for (int j = 0; j < 8; j++) vpat[j] = 1'b1;
    start_op(16'h0500, 17'd4, 1'b1, t);
    rq.push_back('{addr: 16'h0500, cyc: t + 5});
    rq.push_back('{addr: 16'h0501, cyc: t + 6});
    feed(t, 4, 16'h0500);
    step();
    step();
    reset = 1'b1;
    #1;
    check_outputs_zero("midreset");
    step();
    reset = 1'b0;
    step();
    check("post_reset_busy", {31'b0, busy}, 32'd0);
    check("post_reset_reads_left", rq.size(), 0);

    repeat (3) step();
    check("writes_left", wq.size(), 0);
    check("dones_left", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_preload_ctrl.md
# mem_preload_ctrl

Sequencer that owns the memory write/read port during image preload. It streams bytes from a source into memory at `base_addr + i` while holding the CPU off the bus. It optionally reads the region back and compares a modular checksum. It replaces direct array override for loading program images before the CPU runs.

## Interface
- `REG_WIDTH`, 8, data width of memory words and source stream
- `ADDR_WIDTH`, 16, memory address width; memory depth is 2^ADDR_WIDTH
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a preload; sampled only in IDLE
- `abort`  in  1  cancel the current operation; return to IDLE next edge
- `verify_en`  in  1  sampled with `start`; enables the read-back checksum pass
- `base_addr`  in  ADDR_WIDTH  first write address; sampled with `start`
- `length`  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; sampled with `start`
- `src_valid`  in  1  source word available
- `src_data`  in  REG_WIDTH  source word
- `src_ready`  out  1  controller accepts `src_data` this cycle
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_wdata`  out  REG_WIDTH  write data (equals `src_data`)
- `mem_we`  out  1  write strobe
- `mem_re`  out  1  read strobe; `mem_rdata` is valid exactly 1 cycle later
- `mem_rdata`  in  REG_WIDTH  read data
- `cpu_hold`  out  1  CPU must not access memory while high
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle completion pulse
- `error`  out  1  checksum mismatch; valid from `done`, held until next accepted `start`

## Operation
- States: IDLE, LOAD, VERIFY, DRAIN, DONE.
- IDLE: `start`=1 with `length`>0 latches `base_addr`, `length`, `verify_en`, clears `count`, `wsum`, `rsum` and `error`, and moves to LOAD. With `length`=0 it moves directly to DONE, with no memory access and `error`=0.
- LOAD:
  - `src_ready`=1.
  - A handshake (`src_valid && src_ready`) drives `mem_we`=1, `mem_addr`=base+count, `mem_wdata`=`src_data`.
  - On handshake: `wsum += src_data` and `count++`.
  - No handshake means no write; the controller waits indefinitely.
  - After the handshake where `count` reaches `length`-1, go to VERIFY if `verify_en`, else DONE.
- VERIFY: `count` is reset to 0 on entry. Each cycle issues `mem_re`=1, `mem_addr`=base+count, `count++`. After issuing `length` reads, go to DRAIN.
- Read-back accumulate: `rsum += mem_rdata` in every cycle that follows a `mem_re` cycle. This covers VERIFY cycles 2..L and the DRAIN cycle.
- DRAIN: captures the final read word, then goes to DONE.
- DONE:
  - `done`=1 for exactly one cycle.
  - If verify ran, `error` = (`wsum` != `rsum` after the final accumulate).
  - Go to IDLE.
- Arithmetic:
  - Addresses are computed modulo 2^ADDR_WIDTH, so a region past top-of-memory wraps to 0.
  - Sums are modulo 2^REG_WIDTH.
  - `count` is ADDR_WIDTH+1 bits so that `length`=2^ADDR_WIDTH works.
- `abort`: from any non-IDLE state, next state is IDLE. No `done` pulse; `error` is unchanged. Writes already performed remain in memory. `abort` has priority over all other transitions.
- `start` outside IDLE is ignored.
- `cpu_hold` = `busy`.

## Timing
- Reset values:
  - State is IDLE.
  - `src_ready`, `mem_we`, `mem_re`, `cpu_hold`, `busy`, `done` and `error` are 0.
  - `mem_addr` and `mem_wdata` are 0.
  - Counters and sums are 0.
- Reset asserted mid-operation returns to IDLE immediately with all outputs at reset values.
- `src_ready`, `mem_we`, `mem_re`, `mem_addr` and `mem_wdata` are decoded from registered state and `count`. `mem_we` is additionally gated combinationally by `src_valid`.
- Latency with `start` sampled at edge t, `src_valid` held high, and `length`=L>0:
  - LOAD writes occur in cycles t+1..t+L.
  - Without verify: `done` in cycle t+L+1, IDLE at t+L+2.
  - With verify: reads occur in cycles t+L+1..t+2L, DRAIN at t+2L+1, `done` at t+2L+2.
- `length`=0: `done` in cycle t+1.
- `busy` and `cpu_hold` rise in cycle t+1 and fall in the cycle after `done`.
- `mem_we` and `mem_re` are never high in the same cycle.

## Test plan
- base=0x0010, L=4, data 0x11,0x22,0x33,0x44, src_valid always high, no verify -> writes at 0x10..0x13 in 4 consecutive cycles, `done` 5 cycles after start, `error`=0, `busy` high for exactly 5 cycles.
- base=0xFFFE, L=4, verify, memory model correct -> writes at 0xFFFE,0xFFFF,0x0000,0x0001; reads at the same addresses; `done` at t+10; `error`=0.
- Same as the previous case, but memory model corrupts address 0x0000 (0x33→0x34) -> `error`=1 with `done`, held until the next `start`.
- L=3 with src_valid toggling 1,0,0,1,0,1 -> exactly 3 writes on the handshake cycles, no write while src_valid=0, `done` the cycle after the 3rd write.
- `abort` during LOAD after 2 of 8 words -> IDLE next cycle, no `done`, `cpu_hold` low, 2 writes performed; `start` pulses asserted while busy are ignored.
- L=0 -> `done` at t+1, no `mem_we`/`mem_re`. Reset asserted mid-VERIFY -> all outputs 0 immediately, IDLE after release.
